// File: rtl/bus_master_arb.sv
`default_nettype none
// ============================================================================
// Module   : bus_master_arb
// Purpose  : Two-requester bus master that drives one SETUP/STROBE/HOLD read
//            or write cycle on the CS_/OE_/WR_/Addr/data_bus register bus and
//            returns a one-cycle ack to the granted requester.
// Config   : RR_ARB_EN defined   -> round-robin arbitration between requesters
//            RR_ARB_EN undefined -> fixed priority, requester 0 wins ties
// Revision : 1.0  initial release
// ============================================================================
module bus_master_arb #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int STRB_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              CS_,
  output logic              OE_,
  output logic              WR_,
  output logic [ADDR_W-1:0] Addr,
  inout  wire  [DATA_W-1:0] data_bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  // Strobe counter counts down to zero, so it starts at one less than width.
  localparam logic [3:0] CNT_INIT = 4'(STRB_CYC - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              gnt_q, gnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cs_n_q, cs_n_d;
  logic              oe_n_q, oe_n_d;
  logic              wr_n_q, wr_n_d;
  logic              drv_q, drv_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              arb_gnt;
  logic              any_req;

  assign any_req = req0 | req1;

`ifdef RR_ARB_EN
  logic ptr_q, ptr_d;

  // Round-robin pointer: after a transfer completes, favour the other requester.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_HOLD) ptr_d = ~gnt_q;
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= 1'b0;
    else      ptr_q <= ptr_d;
  end

  // Winner selection: a lone requester always wins, ties go to the pointer.
  always_comb begin
    arb_gnt = 1'b0;
    if (req0 && req1) arb_gnt = ptr_q;
    else if (req1)    arb_gnt = 1'b1;
  end
`else
  // Winner selection: requester 0 wins whenever it is requesting.
  always_comb begin
    arb_gnt = 1'b0;
    if (!req0 && req1) arb_gnt = 1'b1;
  end
`endif

  // FSM state and strobe counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: one SETUP, STRB_CYC STROBE cycles, one HOLD, back to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:   if (any_req) state_d = S_SETUP;
      S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = CNT_INIT;
      end
      S_STROBE: begin
        if (cnt_q == 4'd0) state_d = S_HOLD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_HOLD:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Command capture at grant time and read-data capture on leaving STROBE.
  always_comb begin
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (state_q == S_IDLE && any_req) begin
      gnt_d   = arb_gnt;
      wr_d    = arb_gnt ? wr1    : wr0;
      addr_d  = arb_gnt ? addr1  : addr0;
      wdata_d = arb_gnt ? wdata1 : wdata0;
    end
    if (state_q == S_STROBE && cnt_q == 4'd0 && !wr_q) rdata_d = data_bus;
  end

  // Output decode from the next state so every bus pin comes straight off a flop.
  always_comb begin
    cs_n_d = (state_d == S_IDLE);
    oe_n_d = !(state_d == S_STROBE && !wr_d);
    wr_n_d = !(state_d == S_STROBE && wr_d);
    drv_d  = (state_d != S_IDLE) && wr_d;
    ack0_d = (state_d == S_HOLD) && !gnt_d;
    ack1_d = (state_d == S_HOLD) && gnt_d;
  end

  // Command, read data and bus output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cs_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      drv_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cs_n_q  <= cs_n_d;
      oe_n_q  <= oe_n_d;
      wr_n_q  <= wr_n_d;
      drv_q   <= drv_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end

  assign CS_      = cs_n_q;
  assign OE_      = oe_n_q;
  assign WR_      = wr_n_q;
  assign Addr     = addr_q;
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rdata    = rdata_q;
  assign data_bus = drv_q ? wdata_q : {DATA_W{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_bus_master_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_master_arb
// Purpose  : Scoreboard bench for bus_master_arb with a small register slave.
// Revision : 1.0  initial release
// ============================================================================
module tb_bus_master_arb;

  localparam int STRB = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, wr0 = 1'b0, req1 = 1'b0, wr1 = 1'b0;
  logic [7:0] addr0 = 8'h00, wdata0 = 8'h00, addr1 = 8'h00, wdata1 = 8'h00;
  logic       ack0, ack1, CS_, OE_, WR_;
  logic [7:0] rdata, Addr;
  wire  [7:0] data_bus;

  // Slave model: read data driven while OE_ is low.
  logic [7:0] slave_mem [256];
  wire  [7:0] slave_rd = slave_mem[Addr];
  assign data_bus = !OE_ ? slave_rd : 8'bz;

  always #5 clk = ~clk;

  bus_master_arb #(.ADDR_W(8), .DATA_W(8), .STRB_CYC(STRB)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .CS_(CS_), .OE_(OE_), .WR_(WR_), .Addr(Addr),
    .data_bus(data_bus)
  );

  // Strobe-width corner instances (write only, requester 1 idle).
  logic       e_req_a = 1'b0, e_req_b = 1'b0;
  logic       e_ack0_a, e_ack1_a, e_cs_a, e_oe_a, e_wr_a;
  logic       e_ack0_b, e_ack1_b, e_cs_b, e_oe_b, e_wr_b;
  logic [7:0] e_rd_a, e_ad_a, e_rd_b, e_ad_b;
  wire  [7:0] e_bus_a, e_bus_b;

  bus_master_arb #(.ADDR_W(8), .DATA_W(8), .STRB_CYC(1)) u_s1 (
    .clk(clk), .rst(rst),
    .req0(e_req_a), .wr0(1'b1), .addr0(8'h07), .wdata0(8'h99), .ack0(e_ack0_a),
    .req1(1'b0), .wr1(1'b0), .addr1(8'h00), .wdata1(8'h00), .ack1(e_ack1_a),
    .rdata(e_rd_a), .CS_(e_cs_a), .OE_(e_oe_a), .WR_(e_wr_a), .Addr(e_ad_a),
    .data_bus(e_bus_a)
  );

  bus_master_arb #(.ADDR_W(8), .DATA_W(8), .STRB_CYC(15)) u_s15 (
    .clk(clk), .rst(rst),
    .req0(e_req_b), .wr0(1'b1), .addr0(8'h07), .wdata0(8'h99), .ack0(e_ack0_b),
    .req1(1'b0), .wr1(1'b0), .addr1(8'h00), .wdata1(8'h00), .ack1(e_ack1_b),
    .rdata(e_rd_b), .CS_(e_cs_b), .OE_(e_oe_b), .WR_(e_wr_b), .Addr(e_ad_b),
    .data_bus(e_bus_b)
  );

  typedef struct {
    int id;
    int wr;
    int addr;
    int data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int id, input int wr, input int addr, input int data);
    exp_t e;
    e.id = id; e.wr = wr; e.addr = addr; e.data = data;
    sb.push_back(e);
  endtask

  task automatic set_cmd(input int id, input logic r, input logic w,
                         input logic [7:0] a, input logic [7:0] d);
    if (id == 0) begin req0 = r; wr0 = w; addr0 = a; wdata0 = d; end
    else         begin req1 = r; wr1 = w; addr1 = a; wdata1 = d; end
  endtask

  task automatic drop_req(input int id);
    if (id == 0) req0 = 1'b0;
    else         req1 = 1'b0;
  endtask

  // Returns #1 after the edge on which the requester's ack rises.
  task automatic wait_ack(input int id);
    bit got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(posedge clk); #1;
      if ((id == 0) ? ack0 : ack1) got = 1'b1;
    end
    if (!got) chk("ack_timeout", 0, 1);
  endtask

  task automatic xfer(input int id, input int wr, input logic [7:0] a,
                      input logic [7:0] d);
    push(id, wr, a, d);
    @(negedge clk);
    set_cmd(id, 1'b1, wr[0], a, wr[0] ? d : 8'hEE);
    wait_ack(id);
    drop_req(id);
  endtask

  // Holds req high across n writes, loading a new command after each ack.
  task automatic run_req(input int id, input int n);
    @(negedge clk);
    set_cmd(id, 1'b1, 1'b1, 8'(8'h40 + id * 16), 8'(8'h80 + id * 16));
    for (int i = 0; i < n; i++) begin
      wait_ack(id);
      set_cmd(id, 1'b1, 1'b1, 8'(8'h40 + id * 16 + i + 1), 8'(8'h80 + id * 16 + i + 1));
    end
    drop_req(id);
  endtask

  task automatic run_edge(input int k, input int strb);
    int cs_c = 0, st_c = 0, ack_at = 0;
    logic cs, wr, ack;
    @(negedge clk);
    if (k == 0) e_req_a = 1'b1; else e_req_b = 1'b1;
    for (int c = 0; c < 40 && ack_at == 0; c++) begin
      @(negedge clk);
      cs  = (k == 0) ? e_cs_a   : e_cs_b;
      wr  = (k == 0) ? e_wr_a   : e_wr_b;
      ack = (k == 0) ? e_ack0_a : e_ack0_b;
      if (!cs) cs_c++;
      if (!wr) st_c++;
      if (ack) ack_at = cs_c;
    end
    if (k == 0) e_req_a = 1'b0; else e_req_b = 1'b0;
    chk((k == 0) ? "s1_strobe_width" : "s15_strobe_width", st_c, strb);
    chk((k == 0) ? "s1_ack_cycle" : "s15_ack_cycle", ack_at, strb + 2);
  endtask

  // Slave: initial contents, then capture writes during WR_ low.
  initial begin
    for (int i = 0; i < 256; i++) slave_mem[i] = 8'(i);
    slave_mem[2] = 8'h3C;
    forever begin
      @(negedge clk);
      if (rst && !CS_ && !WR_) slave_mem[Addr] = data_bus;
    end
  end

  // Monitor: measures each bus cycle and checks it against the scoreboard on ack.
  initial begin
    int cs_c = 0, oe_c = 0, wr_c = 0;
    logic [7:0] a_seen = 8'h00, bus_first = 8'h00;
    bit bus_ok = 1'b1;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cs_c = 0; oe_c = 0; wr_c = 0;
      end else begin
        if (!CS_) begin
          if (cs_c == 0) begin
            a_seen = Addr; bus_first = data_bus; bus_ok = 1'b1;
          end else if (data_bus != bus_first) begin
            bus_ok = 1'b0;
          end
          cs_c++;
          if (!OE_) oe_c++;
          if (!WR_) wr_c++;
          if (!OE_ && !WR_) chk("oe_wr_overlap", 1, 0);
        end else begin
          cs_c = 0; oe_c = 0; wr_c = 0;
        end
        if (ack0 || ack1) begin
          if (sb.size() == 0) begin
            chk("unexpected_ack", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("ack_id", int'(ack1), e.id);
            chk("ack_single", int'(ack0 & ack1), 0);
            chk("addr", int'(a_seen), e.addr);
            chk("cs_low_cycles", cs_c, STRB + 2);
            if (e.wr != 0) begin
              chk("wr_width", wr_c, STRB);
              chk("oe_in_write", oe_c, 0);
              chk("wdata_on_bus", int'(bus_first), e.data);
              chk("wdata_stable", int'(bus_ok), 1);
            end else begin
              chk("oe_width", oe_c, STRB);
              chk("wr_in_read", wr_c, 0);
              chk("rdata", int'(rdata), e.data);
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", int'(CS_), 1);
    chk("rst_oe", int'(OE_), 1);
    chk("rst_wr", int'(WR_), 1);
    chk("rst_addr", int'(Addr), 0);
    chk("rst_ack0", int'(ack0), 0);
    chk("rst_ack1", int'(ack1), 0);
    chk("rst_rdata", int'(rdata), 0);
    @(negedge clk);
    rst = 1'b1;

    // Single write, read from the other requester, read back.
    xfer(0, 1, 8'h01, 8'hA5);
    xfer(1, 0, 8'h02, 8'h3C);
    xfer(0, 0, 8'h01, 8'hA5);

    // Back-to-back writes with req0 held: exactly one idle cycle between them.
    push(0, 1, 8'h20, 8'h11);
    push(0, 1, 8'h21, 8'h22);
    @(negedge clk);
    set_cmd(0, 1'b1, 1'b1, 8'h20, 8'h11);
    wait_ack(0);
    set_cmd(0, 1'b1, 1'b1, 8'h21, 8'h22);
    @(posedge clk); #1;
    chk("b2b_idle_gap", int'(CS_), 1);
    @(posedge clk); #1;
    chk("b2b_restart", int'(CS_), 0);
    wait_ack(0);
    drop_req(0);
    chk("rdata_hold", int'(rdata), 8'hA5);

    // Reset in the middle of a write strobe; held request restarts afterwards.
    push(0, 1, 8'h05, 8'h77);
    @(negedge clk);
    set_cmd(0, 1'b1, 1'b1, 8'h05, 8'h77);
    begin
      bit seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
        @(posedge clk); #1;
        if (!WR_) seen = 1'b1;
      end
      chk("midrst_reach_strobe", int'(seen), 1);
    end
    #2 rst = 1'b0;
    #1;
    chk("midrst_cs", int'(CS_), 1);
    chk("midrst_wr", int'(WR_), 1);
    chk("midrst_ack", int'(ack0), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    wait_ack(0);
    drop_req(0);

    // Contention with both requests held, from a fresh reset.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
`ifdef RR_ARB_EN
    for (int i = 0; i < 3; i++) begin
      push(0, 1, 8'h40 + i, 8'h80 + i);
      push(1, 1, 8'h50 + i, 8'h90 + i);
    end
`else
    for (int i = 0; i < 3; i++) push(0, 1, 8'h40 + i, 8'h80 + i);
    for (int i = 0; i < 3; i++) push(1, 1, 8'h50 + i, 8'h90 + i);
`endif
    fork
      run_req(0, 3);
      run_req(1, 3);
    join

    // Strobe width corners.
    fork
      run_edge(0, 1);
      run_edge(1, 15);
    join

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
